// File: rtl/bram_pkg.sv
// Shared constants for the byte-enabled true-dual-port RAM family.
// RDW_MODE selects what a port's dout shows on the cycle it writes.
package bram_pkg;

   localparam int WRITE_FIRST = 0;
   localparam int READ_FIRST  = 1;
   localparam int NO_CHANGE   = 2;

   function automatic bit rdw_mode_ok(input int mode);
      return (mode == WRITE_FIRST) || (mode == READ_FIRST) || (mode == NO_CHANGE);
   endfunction

endpackage

// File: rtl/bram_tdp_be_if.sv
// One RAM access port: request fields driven by the master, read result returned by the slave.
// No backpressure: a request is consumed every cycle that en is high.
interface bram_tdp_be_if #(
   parameter int DATA_WIDTH = 72,
   parameter int ADDR_WIDTH = 10,
   parameter int NB         = 8
);
   logic                  en;
   logic [NB-1:0]         we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dvalid;

   modport master (output en, we, addr, din, input dout, dvalid);
   modport slave  (input en, we, addr, din, output dout, dvalid);
endinterface

// File: rtl/bram_out_pipe.sv
// Fixed-length delay line for read data and its valid flag; synchronous clear on rst.
// Latency STAGES cycles (combinational pass-through when STAGES is 0); never stalls.
module bram_out_pipe #(
   parameter int WIDTH  = 72,
   parameter int STAGES = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_dat,
   input  logic             in_vld,
   output logic [WIDTH-1:0] out_dat,
   output logic             out_vld
);

   generate
      if (STAGES == 0) begin : g_bypass
         logic unused_clk_rst;
         assign unused_clk_rst = clk | rst;
         assign out_dat = in_dat;
         assign out_vld = in_vld;
      end else begin : g_stages
         logic [WIDTH-1:0]  dat_q [STAGES];
         logic [STAGES-1:0] vld_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < STAGES; i++) begin
                  dat_q[i] <= '0;
               end
               vld_q <= '0;
            end else begin
               dat_q[0] <= in_dat;
               vld_q[0] <= in_vld;
               for (int i = 1; i < STAGES; i++) begin
                  dat_q[i] <= dat_q[i-1];
                  vld_q[i] <= vld_q[i-1];
               end
            end
         end

         assign out_dat = dat_q[STAGES-1];
         assign out_vld = vld_q[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/bram_tdp_be.sv
// True dual-port RAM with per-lane write enables and selectable read-during-write behaviour.
// Read data valid RD_LATENCY cycles after the access; fully pipelined, no backpressure.
module bram_tdp_be
   import bram_pkg::*;
#(
   parameter int DATA_WIDTH = 72,
   parameter int ADDR_WIDTH = 10,
   parameter int BYTE_WIDTH = 9,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = WRITE_FIRST
) (
   input  logic         clk,
   input  logic         rst,
   bram_tdp_be_if.slave a,
   bram_tdp_be_if.slave b
);

   localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Ports folded into index 0 (A) and 1 (B) so both share one code path.
   logic                  p_en     [2];
   logic [NB-1:0]         p_we     [2];
   logic [ADDR_WIDTH-1:0] p_addr   [2];
   logic [DATA_WIDTH-1:0] p_din    [2];
   logic [DATA_WIDTH-1:0] p_dout   [2];
   logic                  p_dvalid [2];

   assign p_en[0]   = a.en;
   assign p_we[0]   = a.we;
   assign p_addr[0] = a.addr;
   assign p_din[0]  = a.din;
   assign p_en[1]   = b.en;
   assign p_we[1]   = b.we;
   assign p_addr[1] = b.addr;
   assign p_din[1]  = b.din;

   assign a.dout   = p_dout[0];
   assign a.dvalid = p_dvalid[0];
   assign b.dout   = p_dout[1];
   assign b.dvalid = p_dvalid[1];

   // B is applied before A so that A's lanes win when both hit the same word and lane.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NB; i++) begin
            if (p_en[1] && p_we[1][i]) begin
               mem[p_addr[1]][i*BYTE_WIDTH +: BYTE_WIDTH] <= p_din[1][i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (p_en[0] && p_we[0][i]) begin
               mem[p_addr[0]][i*BYTE_WIDTH +: BYTE_WIDTH] <= p_din[0][i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   generate
      for (genvar p = 0; p < 2; p++) begin : g_port
         logic [DATA_WIDTH-1:0] s1_dat;
         logic                  s1_vld;

         // Reads sample mem before this edge's writes land: cross-port reads see the old word.
         always_ff @(posedge clk) begin
            if (rst) begin
               s1_dat <= '0;
               s1_vld <= 1'b0;
            end else if (!p_en[p]) begin
               s1_vld <= 1'b0;
            end else if (p_we[p] == '0) begin
               s1_dat <= mem[p_addr[p]];
               s1_vld <= 1'b1;
            end else if (RDW_MODE == WRITE_FIRST) begin
               for (int i = 0; i < NB; i++) begin
                  s1_dat[i*BYTE_WIDTH +: BYTE_WIDTH] <= p_we[p][i]
                     ? p_din[p][i*BYTE_WIDTH +: BYTE_WIDTH]
                     : mem[p_addr[p]][i*BYTE_WIDTH +: BYTE_WIDTH];
               end
               s1_vld <= 1'b1;
            end else if (RDW_MODE == READ_FIRST) begin
               s1_dat <= mem[p_addr[p]];
               s1_vld <= 1'b1;
            end else begin
               s1_vld <= 1'b0;
            end
         end

         bram_out_pipe #(
            .WIDTH  (DATA_WIDTH),
            .STAGES (RD_LATENCY - 1)
         ) u_out_pipe (
            .clk     (clk),
            .rst     (rst),
            .in_dat  (s1_dat),
            .in_vld  (s1_vld),
            .out_dat (p_dout[p]),
            .out_vld (p_dvalid[p])
         );
      end
   endgenerate

endmodule

// File: tb/tb_bram_tdp_be.sv
// Four RAM instances (WRITE_FIRST, READ_FIRST, NO_CHANGE at latency 1; WRITE_FIRST at latency 3)
// driven with identical directed and random traffic, checked against a cycle-indexed reference.
module tb_bram_tdp_be;
   import bram_pkg::*;

   localparam int DW   = 72;
   localparam int AW   = 10;
   localparam int BW   = 9;
   localparam int NB   = 8;
   localparam int NDUT = 4;
   localparam int NCYC = 2048;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_en, b_en;
   logic [NB-1:0] a_we, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_din, b_din;

   logic [NDUT-1:0][1:0][DW-1:0] dout_o;
   logic [NDUT-1:0][1:0]         vld_o;

   int checks   = 0;
   int failures = 0;

   function automatic int lat_of(input int g);
      return (g == 3) ? 3 : 1;
   endfunction

   function automatic int mode_of(input int g);
      return (g == 1) ? READ_FIRST : (g == 2) ? NO_CHANGE : WRITE_FIRST;
   endfunction

   generate
      for (genvar g = 0; g < NDUT; g++) begin : g_dut
         bram_tdp_be_if ia ();
         bram_tdp_be_if ib ();
         assign ia.en   = a_en;
         assign ia.we   = a_we;
         assign ia.addr = a_addr;
         assign ia.din  = a_din;
         assign ib.en   = b_en;
         assign ib.we   = b_we;
         assign ib.addr = b_addr;
         assign ib.din  = b_din;
         assign dout_o[g][0] = ia.dout;
         assign vld_o[g][0]  = ia.dvalid;
         assign dout_o[g][1] = ib.dout;
         assign vld_o[g][1]  = ib.dvalid;

         bram_tdp_be #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .BYTE_WIDTH (BW),
            .RD_LATENCY (lat_of(g)),
            .RDW_MODE   (mode_of(g))
         ) u_dut (
            .clk (clk),
            .rst (rst),
            .a   (ia),
            .b   (ib)
         );
      end
   endgenerate

   always #5 clk = ~clk;

   // Reference: memory image, per-cycle access result, and what each output should show now.
   logic [DW-1:0] mem_m  [1<<AW];
   logic [DW-1:0] slot_d [NDUT][2][NCYC];
   logic          slot_v [NDUT][2][NCYC];
   logic [DW-1:0] vis_d  [NDUT][2];
   logic          vis_v  [NDUT][2];
   int            cyc = 0;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                           input logic [NB-1:0] we);
      logic [DW-1:0] r;
      r = old_w;
      for (int i = 0; i < NB; i++) begin
         if (we[i]) r[i*BW +: BW] = new_w[i*BW +: BW];
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] rnd_word();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      if (!$isunknown(exp)) begin
         checks++;
         assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
         end
      end
   endtask

   task automatic model_edge();
      logic [DW-1:0] old_w [2];
      logic          en    [2];
      logic [NB-1:0] we    [2];
      logic [DW-1:0] din   [2];
      logic          v;
      logic [DW-1:0] dt;
      int            k, lat;
      en[0] = a_en;  we[0] = a_we;  din[0] = a_din;  old_w[0] = mem_m[a_addr];
      en[1] = b_en;  we[1] = b_we;  din[1] = b_din;  old_w[1] = mem_m[b_addr];
      for (int d = 0; d < NDUT; d++) begin
         for (int p = 0; p < 2; p++) begin
            v  = 1'b0;
            dt = '0;
            if (!rst && en[p]) begin
               if (we[p] == '0) begin
                  v = 1'b1; dt = old_w[p];
               end else if (mode_of(d) == WRITE_FIRST) begin
                  v = 1'b1; dt = merge(old_w[p], din[p], we[p]);
               end else if (mode_of(d) == READ_FIRST) begin
                  v = 1'b1; dt = old_w[p];
               end
            end
            slot_d[d][p][cyc] = dt;
            slot_v[d][p][cyc] = v;
         end
      end
      if (!rst) begin
         if (b_en) mem_m[b_addr] = merge(mem_m[b_addr], b_din, b_we);
         if (a_en) mem_m[a_addr] = merge(mem_m[a_addr], a_din, a_we);
      end
      for (int d = 0; d < NDUT; d++) begin
         lat = lat_of(d);
         for (int p = 0; p < 2; p++) begin
            if (rst) begin
               for (k = cyc - lat + 1; k <= cyc; k++) begin
                  if (k >= 0) slot_v[d][p][k] = 1'b0;
               end
               vis_d[d][p] = '0;
               vis_v[d][p] = 1'b0;
            end else begin
               k = cyc - lat + 1;
               if (k >= 0 && slot_v[d][p][k]) begin
                  vis_d[d][p] = slot_d[d][p][k];
                  vis_v[d][p] = 1'b1;
               end else begin
                  vis_v[d][p] = 1'b0;
               end
            end
         end
      end
      cyc++;
   endtask

   task automatic check_all();
      for (int d = 0; d < NDUT; d++) begin
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("c%0d_d%0d_p%0d_dout", cyc, d, p), dout_o[d][p], vis_d[d][p]);
            chk($sformatf("c%0d_d%0d_p%0d_dvalid", cyc, d, p), DW'(vld_o[d][p]), DW'(vis_v[d][p]));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle();
      a_en = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
      b_en = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
   endtask

   initial begin
      int first, pulses;
      logic seen;

      rst = 1'b1;
      idle();
      repeat (3) tick();
      chk("reset_a_dout", dout_o[0][0], '0);
      chk("reset_b_dvalid_l3", DW'(vld_o[3][1]), '0);
      rst = 1'b0;

      // Give every address used later a defined value.
      for (int i = 0; i < 16; i++) begin
         a_en = 1'b1; a_we = '1; a_addr = AW'(i);      a_din = rnd_word();
         b_en = 1'b1; b_we = '1; b_addr = AW'(i + 16); b_din = rnd_word();
         tick();
      end

      idle();
      a_en = 1'b1; a_we = '1; a_addr = 10'd5; a_din = 72'h0123456789ABCDEF00;
      tick();
      idle();
      b_en = 1'b1; b_addr = 10'd5;
      tick();
      chk("a_wr_b_rd_dout", dout_o[0][1], 72'h0123456789ABCDEF00);
      chk("a_wr_b_rd_dvalid", DW'(vld_o[0][1]), DW'(1));

      idle();
      a_en = 1'b1; a_we = '1; a_addr = 10'd7; a_din = '1;
      tick();
      a_we = 8'h01; a_din = '0;
      tick();
      chk("lane_wr_wf_dout", dout_o[0][0], 72'hFFFFFFFFFFFFFFFE00);
      chk("lane_wr_rf_dout", dout_o[1][0], 72'hFFFFFFFFFFFFFFFFFF);
      chk("lane_wr_rf_dvalid", DW'(vld_o[1][0]), DW'(1));
      chk("lane_wr_nc_dvalid", DW'(vld_o[2][0]), '0);
      a_we = '0;
      tick();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("lane_rd_d%0d", d), dout_o[d][0], 72'hFFFFFFFFFFFFFFFE00);
      end

      idle();
      a_en = 1'b1; a_we = 8'hF0; a_addr = 10'd3; a_din = 72'hAAAAAAAAAAAAAAAAAA;
      b_en = 1'b1; b_we = 8'hFF; b_addr = 10'd3; b_din = 72'h555555555555555555;
      tick();
      idle();
      a_en = 1'b1; a_addr = 10'd3;
      tick();
      chk("collision_merge", dout_o[0][0], 72'hAAAAAAAAA555555555);

      idle();
      a_en = 1'b1; a_we = '1; a_addr = 10'd9; a_din = 72'h11;
      tick();
      a_din = 72'h22;
      b_en = 1'b1; b_addr = 10'd9;
      tick();
      chk("xport_rdw_old", dout_o[0][1], 72'h11);
      idle();
      b_en = 1'b1; b_addr = 10'd9;
      tick();
      chk("xport_next_new", dout_o[0][1], 72'h22);

      idle();
      repeat (3) tick();
      first  = -1;
      pulses = 0;
      for (int k = 0; k < 19; k++) begin
         idle();
         if (k < 16) begin
            a_en = 1'b1; a_addr = AW'(k);
         end
         tick();
         if (vld_o[3][0]) begin
            if (first < 0) first = k;
            pulses++;
         end
      end
      chk("l3_pulse_count", DW'(pulses), DW'(16));
      chk("l3_first_pulse", DW'(first), DW'(2));

      idle();
      a_en = 1'b1; a_addr = 10'd5;
      tick();
      rst = 1'b1;
      a_we = '1; a_din = 72'hDEADDEADDEADDEADDE;
      tick();
      chk("rst_flush_dout", dout_o[3][0], '0);
      rst = 1'b0;
      idle();
      seen = 1'b0;
      repeat (4) begin
         tick();
         seen |= vld_o[3][0];
      end
      chk("rst_no_dvalid", DW'(seen), '0);
      chk("rst_dout_zero", dout_o[3][0], '0);
      a_en = 1'b1; a_addr = 10'd5;
      tick();
      idle();
      repeat (2) tick();
      chk("rst_mem_intact", dout_o[3][0], 72'h0123456789ABCDEF00);
      chk("rst_mem_dvalid", DW'(vld_o[3][0]), DW'(1));

      for (int n = 0; n < 500; n++) begin
         rst    = ($urandom_range(0, 49) == 0);
         a_en   = ($urandom_range(0, 3) != 0);
         a_we   = ($urandom_range(0, 2) == 0) ? '0 : NB'($urandom());
         a_addr = AW'($urandom_range(0, 31));
         a_din  = rnd_word();
         b_en   = ($urandom_range(0, 3) != 0);
         b_we   = ($urandom_range(0, 2) == 0) ? '0 : NB'($urandom());
         b_addr = ($urandom_range(0, 3) == 0) ? a_addr : AW'($urandom_range(0, 31));
         b_din  = rnd_word();
         tick();
      end
      rst = 1'b0;
      idle();
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bram_tdp_be.md
BRAM_TDP_BE -- requirements
Module: bram_tdp_be

Interface
REQ-001 Parameter DATA_WIDTH, default 72: word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10: address width; depth = 2**ADDR_WIDTH words.
REQ-003 Parameter BYTE_WIDTH, default 9: lane width in bits; DATA_WIDTH SHALL be an integer multiple of it; NB = DATA_WIDTH/BYTE_WIDTH.
REQ-004 Parameter RD_LATENCY, default 1, range 1..3: cycles from the access to valid read data.
REQ-005 Parameter RDW_MODE, default WRITE_FIRST; values WRITE_FIRST, READ_FIRST, NO_CHANGE: port read-during-write behaviour.
REQ-006 clk  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 a_en  in  1  port A access enable.
REQ-009 a_we  in  NB  port A per-lane write enables; this is a write access when a_en=1 and a_we!=0.
REQ-010 a_addr  in  ADDR_WIDTH  port A word address.
REQ-011 a_din  in  DATA_WIDTH  port A write data.
REQ-012 a_dout  out  DATA_WIDTH  port A read data.
REQ-013 a_dvalid  out  1  a_dout carries the result of an access.
REQ-014 b_en, b_we, b_addr, b_din, b_dout, b_dvalid SHALL mirror REQ-008..013 for port B.

Function
REQ-015 Both ports SHALL be fully independent read/write ports on one shared memory array.
REQ-016 On an enabled write, only lanes with we[i]=1 SHALL update; the other lanes SHALL keep their stored value.
REQ-017 An enabled read (we=0) of addr SHALL present mem[addr] on dout, with dvalid=1, exactly RD_LATENCY cycles after the access.
REQ-018 On a write in WRITE_FIRST mode, dout SHALL show the merged word: new lanes where we=1, old lanes elsewhere. dvalid SHALL be 1.
REQ-019 On a write in READ_FIRST mode, dout SHALL show the pre-write word. dvalid SHALL be 1.
REQ-020 On a write in NO_CHANGE mode, dout SHALL hold its previous value and dvalid SHALL be 0 for that slot.
REQ-021 With en=0, dvalid SHALL be 0 RD_LATENCY cycles later and dout SHALL hold its value.
REQ-022 Each port's dout/dvalid pipeline SHALL advance every cycle, with no stall input. Back-to-back accesses SHALL yield back-to-back results.
REQ-023 If both ports write the same address in the same cycle, then per lane:
- port A's data SHALL win where both enable that lane;
- each port's enabled lanes SHALL apply where only one port enables it.
REQ-024 A read on one port of an address written by the other port in the same cycle SHALL return the pre-write word.
REQ-025 Writes SHALL be visible to either port's read issued on the following cycle.

Reset
REQ-026 While rst=1: a_dout=0, b_dout=0, a_dvalid=0, b_dvalid=0, and all pipeline stages SHALL be cleared.
REQ-027 Memory contents SHALL NOT be cleared by rst.
REQ-028 Accesses presented while rst=1 SHALL be ignored, with no write and no dvalid.
REQ-029 Reset asserted mid-pipeline SHALL flush in-flight results; the first dvalid after reset SHALL come from an access issued after rst falls.

Structure
REQ-030 RDW_MODE encoding constants (WRITE_FIRST=0, READ_FIRST=1, NO_CHANGE=2) SHALL live in shared package bram_pkg.
REQ-031 Sub-module bram_out_pipe SHALL implement the (RD_LATENCY-1)-stage dout+dvalid delay line with synchronous clear. It SHALL be instantiated once per port.
REQ-032 The memory array SHALL be coded inferable as block RAM, with per-lane write loops and no vendor primitives.

Verification
REQ-033 Defaults, RD_LATENCY=1: write A addr 5 = 0x0123456789ABCDEF00, then B read addr 5 -> b_dout=0x0123456789ABCDEF00, b_dvalid=1 one cycle after the read.
REQ-034 Lane write: addr 7 holds all-ones; A writes 0 with a_we=8'h01 -> subsequent read = all-ones except low 9 bits = 0. Repeat for RDW_MODE=WRITE_FIRST/READ_FIRST/NO_CHANGE; check the write-cycle dout per REQ-018..020.
REQ-035 Collision: A writes 0xAA.., we=8'hF0 and B writes 0x55.., we=8'hFF to addr 3 in the same cycle -> upper 4 lanes = A data, lower 4 = B data.
REQ-036 RD_LATENCY=3: reads of addresses 0..15 on consecutive cycles -> 16 consecutive dvalid pulses starting 3 cycles after the first read, data in order.
REQ-037 Reset: assert rst one cycle after a read with RD_LATENCY=3 -> no dvalid for that read, dout=0; memory data intact on a later read.
REQ-038 Cross-port read-during-write: B reads addr 9 (old 0x11) while A writes 0x22 -> b_dout=0x11; next-cycle B read -> 0x22.
